// File: rtl/dec32_pkg.sv
// ----------------------------------------------------------------------------
// dec32_pkg
// Shared constants and types for the 5-to-32 one-hot decoder stream block.
//   DEC32_WIDTH : width of the decoded one-hot word
//   DEC32_IDX_W : width of the binary index
//   DEC32_CNT_W : width of the accepted-word counter
//   onehot_t    : 32-bit one-hot word type
// ----------------------------------------------------------------------------
package dec32_pkg;

  localparam int DEC32_WIDTH = 32;
  localparam int DEC32_IDX_W = 5;
  localparam int DEC32_CNT_W = 16;

  typedef logic [DEC32_WIDTH-1:0] onehot_t;
  typedef logic [DEC32_IDX_W-1:0] idx_t;
  typedef logic [DEC32_CNT_W-1:0] cnt_t;

endpackage : dec32_pkg

// File: rtl/dec32_onehot.sv
// ----------------------------------------------------------------------------
// dec32_onehot
// Purely combinational 5-to-32 decoder. Sets bit idx of word, or produces an
// all-zero word when zero is asserted (idx is then ignored).
// Ports:
//   idx  : in  binary index 0..31
//   zero : in  request the all-zero word
//   word : out one-hot (or all-zero) word, LSB = index 0
// ----------------------------------------------------------------------------
module dec32_onehot
  import dec32_pkg::*;
(
  input  idx_t    idx,
  input  logic    zero,
  output onehot_t word
);

  always_comb begin
    // NOTE: assign a default before any conditional write so every path
    // drives the output and no latch is inferred.
    word = '0;
    if (!zero) begin
      word[idx] = 1'b1;
    end
  end

endmodule : dec32_onehot

// File: rtl/decoder_32bit_1cc_stream.sv
// ----------------------------------------------------------------------------
// decoder_32bit_1cc_stream
// Valid/ready streaming 5-to-32 one-hot decoder with a single output register
// stage (1-cycle latency, full throughput) and a count of accepted words.
//
// Optional feature (macro DEC32_ACCUM_EN): a sticky OR-accumulator of every
// accepted word, exposed as acc_mask and cleared by acc_clr.
//
// Ports:
//   clk        : in  sole clock, rising edge
//   rst        : in  synchronous active-high reset
//   in_valid   : in  upstream presents a code word
//   in_ready   : out block accepts a code word this cycle
//   in_idx     : in  binary index 0..31
//   in_zero    : in  code word means "no bit set" (in_idx ignored)
//   out_valid  : out out_onehot holds a decoded word
//   out_ready  : in  downstream consumes the word this cycle
//   out_onehot : out decoded word
//   out_count  : out words accepted since reset (wraps at 16 bits)
//   acc_clr    : in  (DEC32_ACCUM_EN only) clear the accumulator
//   acc_mask   : out (DEC32_ACCUM_EN only) OR of accepted words
// ----------------------------------------------------------------------------
module decoder_32bit_1cc_stream
  import dec32_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEC32_IDX_W-1:0] in_idx,
  input  logic                   in_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEC32_WIDTH-1:0] out_onehot,
`ifdef DEC32_ACCUM_EN
  input  logic                   acc_clr,
  output logic [DEC32_WIDTH-1:0] acc_mask,
`endif
  output logic [DEC32_CNT_W-1:0] out_count
);

  onehot_t dec_word;
  logic    accept;

  dec32_onehot u_onehot (
    .idx  (in_idx),
    .zero (in_zero),
    .word (dec_word)
  );

  // The output register can take a new word when it is empty or is being
  // drained this cycle. During reset the port reads ready, but the reset
  // term below keeps anything from being accepted.
  assign in_ready = rst | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~rst;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (rst) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_count  <= '0;
    end else begin
      if (accept) begin
        // Covers the simultaneous consume+accept case: the new word replaces
        // the old one and out_valid stays high with no bubble.
        out_valid  <= 1'b1;
        out_onehot <= dec_word;
        out_count  <= out_count + 1'b1;
      end else if (out_ready) begin
        // out_onehot deliberately keeps its last value once consumed.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DEC32_ACCUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_mask <= '0;
    end else if (acc_clr) begin
      // Clear wins over the history, but a same-cycle accept still lands.
      acc_mask <= accept ? dec_word : '0;
    end else if (accept) begin
      acc_mask <= acc_mask | dec_word;
    end
  end
`endif

endmodule : decoder_32bit_1cc_stream

// File: tb/tb_decoder_32bit_1cc_stream.sv
// ----------------------------------------------------------------------------
// tb_decoder_32bit_1cc_stream
// Scoreboard bench for decoder_32bit_1cc_stream. The stimulus process drives
// directed vectors on posedge+1; a monitor on the falling edge tracks a
// reference handshake model, pushes expected words on accept and pops/compares
// them when the output is consumed. Define DEC32_ACCUM_EN to exercise the
// accumulator ports.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_32bit_1cc_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_idx;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_onehot;
  logic [15:0] out_count;
`ifdef DEC32_ACCUM_EN
  logic        acc_clr;
  logic [31:0] acc_mask;
`endif

  decoder_32bit_1cc_stream dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
`ifdef DEC32_ACCUM_EN
    .acc_clr    (acc_clr),
    .acc_mask   (acc_mask),
`endif
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference OR-encoder (32-to-5): used for the round-trip check.
  function automatic logic [4:0] encode(input logic [31:0] w);
    logic [4:0] r = '0;
    for (int i = 0; i < 32; i++) if (w[i]) r |= 5'(i);
    return r;
  endfunction

  typedef struct {
    logic [31:0] word;
    logic [15:0] cnt;
    logic [4:0]  idx;
  } exp_t;

  exp_t        sb[$];
  logic        m_valid = 1'b0;
  logic [15:0] m_count = '0;

  // Monitor / reference model, evaluated mid-cycle with inputs stable.
  always @(negedge clk) begin
    exp_t e;
    logic acc;
    if (rst) begin
      check("in_ready_in_reset", {31'b0, in_ready}, 32'd1);
      sb.delete();
      m_valid = 1'b0;
      m_count = '0;
    end else begin
      check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("in_ready", {31'b0, in_ready}, {31'b0, (~m_valid | out_ready)});
      if (m_valid && out_ready) begin
        e = sb.pop_front();
        check("sb_word", out_onehot, e.word);
        check("sb_count", {16'b0, out_count}, {16'b0, e.cnt});
        check("sb_roundtrip", {27'b0, encode(out_onehot)}, {27'b0, e.idx});
      end
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        m_count = m_count + 16'd1;
        e.word  = in_zero ? 32'h0 : (32'h1 << in_idx);
        e.idx   = in_zero ? 5'd0 : in_idx;
        e.cnt   = m_count;
        sb.push_back(e);
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int WRAP_N = 65536 - 33;

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_idx = 5'd9; in_zero = 1'b0; out_ready = 1'b1;
`ifdef DEC32_ACCUM_EN
    acc_clr = 1'b0;
`endif
    // Reset held two cycles with in_valid high: nothing may be accepted.
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("reset_valid",  {31'b0, out_valid}, 32'd0);
    check("reset_onehot", out_onehot, 32'h0);
    check("reset_count",  {16'b0, out_count}, 32'd0);
`ifdef DEC32_ACCUM_EN
    check("reset_acc", acc_mask, 32'h0);
`endif
    tick();

    // Single word.
    in_valid = 1'b1; in_idx = 5'd5; in_zero = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_onehot", out_onehot, 32'h0000_0020);
    check("single_valid",  {31'b0, out_valid}, 32'd1);
    check("single_count",  {16'b0, out_count}, 32'd1);
    tick();

    // Backpressure: idx 31 stalled for three cycles.
    in_valid = 1'b1; in_idx = 5'd31; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold",     out_onehot, 32'h8000_0000);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {31'b0, in_ready}, 32'd1);
    tick();

    // Reset again (with a pending request) so streaming counts from zero.
    rst = 1'b1; in_valid = 1'b1; in_idx = 5'd7;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();

    // Streaming idx 0..31 back-to-back.
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_idx = 5'(i); in_zero = 1'b0;
      tick();
    end
    in_zero = 1'b1; in_idx = 5'd17;
    @(negedge clk);
    check("stream_count", {16'b0, out_count}, 32'd32);
    check("stream_last",  out_onehot, 32'h8000_0000);
    tick();
    in_valid = 1'b0; in_zero = 1'b0;
    @(negedge clk);
    check("zero_word",  out_onehot, 32'h0);
    check("zero_valid", {31'b0, out_valid}, 32'd1);
    check("zero_count", {16'b0, out_count}, 32'd33);
    tick();

    // Counter wrap: total accepts since reset reaches 65536.
    for (int i = 0; i < WRAP_N; i++) begin
      in_valid = 1'b1; in_idx = 5'(i % 32); in_zero = 1'(i % 7 == 0);
      tick();
    end
    in_valid = 1'b0; in_zero = 1'b0;
    @(negedge clk);
    check("wrap_count", {16'b0, out_count}, 32'd0);
    tick();

`ifdef DEC32_ACCUM_EN
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0; in_valid = 1'b1; in_idx = 5'd3;
    tick();
    in_idx = 5'd7;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("acc_or", acc_mask, 32'h0000_0088);
    tick();
    acc_clr = 1'b1; in_valid = 1'b1; in_idx = 5'd1;
    tick();
    acc_clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("acc_clr_accept", acc_mask, 32'h0000_0002);
    tick();
`endif

    tick(); tick(); tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder_32bit_1cc_stream
